// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word accesses to a word-wide data memory, with
// read-modify-write for sub-word stores. Define LSU_ALIGN_CHECK_EN to fault misaligned accesses.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        dm_ena,
  output logic        dm_rena,
  output logic        dm_wena,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        misalign_now;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign dm_addr = {addr_q[31:2], 2'b00};

`ifdef LSU_ALIGN_CHECK_EN
  // Reserved size 2'b11 behaves as a word, so size[1] selects word alignment rules.
  assign misalign_now = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`else
  assign misalign_now = 1'b0;
`endif

  // NOTE: combinational blocks use blocking '=' and assign every output first,
  // so no latch is inferred for any path through the case statements.
  always_comb begin
    lane_byte = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_half = dm_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = {{24{sext_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{sext_q & lane_half[15]}}, lane_half};
      default: load_ext = dm_rdata;
    endcase
  end

  always_comb begin
    merged = dm_rdata;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<='; every register here is
  // reset, and the async reset also drops dm_wena before the next write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      size_q   <= 2'b00;
      sext_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      misalign <= 1'b0;
      rdata    <= '0;
      dm_ena   <= 1'b0;
      dm_rena  <= 1'b0;
      dm_wena  <= 1'b0;
      dm_wdata <= '0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      dm_ena   <= 1'b0;
      dm_rena  <= 1'b0;
      dm_wena  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            size_q  <= size;
            sext_q  <= sign_ext;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
            if (misalign_now) begin
              state    <= DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else if (!we) begin
              state   <= LOAD;
              dm_ena  <= 1'b1;
              dm_rena <= 1'b1;
            end else if (size[1]) begin
              state    <= WRITE;
              dm_ena   <= 1'b1;
              dm_wena  <= 1'b1;
              dm_wdata <= wdata;
            end else begin
              state   <= RMW_RD;
              dm_ena  <= 1'b1;
              dm_rena <= 1'b1;
            end
          end
        end
        LOAD: begin
          rdata <= load_ext;
          state <= DONE;
          done  <= 1'b1;
        end
        RMW_RD: begin
          dm_wdata <= merged;
          state    <= WRITE;
          dm_ena   <= 1'b1;
          dm_wena  <= 1'b1;
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req  in  1  access request, sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-007 sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend sub-word data.
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  32  store data, right-aligned for sub-word stores.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 rdata  out  32  extended load result, registered.
REQ-013 misalign  out  1  alignment fault flag, valid with done (tied 0 without LSU_ALIGN_CHECK_EN).
REQ-014 dm_ena, dm_rena, dm_wena  out  1 each  data-memory enables; dm_wena causes a write at the next rising edge.
REQ-015 dm_addr  out  32  word-aligned address {addr_q[31:2],2'b00}.
REQ-016 dm_wdata  out  32  full word written to memory.
REQ-017 dm_rdata  in  32  combinational read word for dm_addr.

Function
REQ-018 The FSM SHALL use states IDLE, LOAD, RMW_RD, WRITE, DONE.
REQ-019 In IDLE with req=1, the block SHALL latch we, size, sign_ext, addr and wdata, then move to:
- LOAD for a load.
- WRITE for a word store.
- RMW_RD for a byte or halfword store.
REQ-020 LOAD SHALL drive dm_ena=dm_rena=1, capture the extracted and extended data into rdata, and go to DONE; accept-to-done latency is 2 cycles.
REQ-021 RMW_RD SHALL drive dm_ena=dm_rena=1, capture dm_rdata into a merge register, and go to WRITE.
REQ-022 WRITE SHALL drive dm_ena=dm_wena=1 for exactly one cycle with the merged word, then go to DONE.
- Word-store latency is 2 cycles.
- Sub-word-store latency is 3 cycles.
REQ-023 DONE SHALL pulse done=1 for one cycle and return to IDLE; a new req is accepted no earlier than the cycle after DONE.
REQ-024 Byte lanes are little-endian: byte lane k is bits [8k+7:8k] for addr[1:0]=k, and halfword lane h is bits [16h+15:16h] for h=addr[1].
REQ-025 A sub-word store SHALL replace only the addressed lane with wdata[7:0] or wdata[15:0] and preserve all other bytes of the word read in RMW_RD.
REQ-026 Sub-word loads SHALL be zero-extended or sign-extended to 32 bits according to sign_ext; word loads SHALL pass through unchanged.
REQ-027 rdata SHALL hold its value until the next successful load completes; stores SHALL NOT modify it.
REQ-028 req SHALL be ignored while busy=1, and latched operands SHALL NOT change mid-operation.
REQ-029 dm_ena, dm_rena and dm_wena SHALL be 0 in IDLE and DONE.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force state IDLE, with busy, done, misalign, dm_ena, dm_rena and dm_wena at 0, and rdata, dm_addr and dm_wdata at 0.
REQ-031 A reset asserted during WRITE SHALL deassert dm_wena asynchronously so that no memory write occurs at the next edge.
REQ-032 After rst_n rises, the first req SHALL be accepted on the first rising edge with req=1.

Configuration
REQ-033 With LSU_ALIGN_CHECK_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=00 SHALL go directly from IDLE to DONE.
- No memory enable is asserted.
- done=1 and misalign=1 in DONE.
- rdata is unchanged.
REQ-034 Without LSU_ALIGN_CHECK_EN, misalign SHALL be tied 0.
- Word accesses ignore addr[1:0].
- Halfword accesses ignore addr[0].

Verification
REQ-035 Memory word 0x10010000=0x11223344; load byte addr 0x10010002, sign_ext=1 -> done at accept+2, rdata=0x00000022.
REQ-036 Memory word=0x80FF7F01; load halfword addr 0x10010002, sign_ext=1 -> rdata=0xFFFF80FF; with sign_ext=0 -> rdata=0x000080FF.
REQ-037 Memory word=0xAABBCCDD; store byte 0x5A at addr 0x10010001 -> one dm_wena pulse with dm_wdata=0xAABB5ADD, done at accept+3.
REQ-038 Word store 0xDEADBEEF at addr 0x10010004, with req held high throughout -> exactly one write, busy for 2 cycles, and no second accept until after done.
REQ-039 rst_n=0 asserted during WRITE of a sub-word store -> dm_wena=0 immediately, memory word unchanged, state IDLE.
REQ-040 With LSU_ALIGN_CHECK_EN, word load at addr 0x10010002 -> done at accept+1, misalign=1, no dm_ena, rdata unchanged.
